// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// controller state encoding and the default operand width.
package seq_mult_pkg;

    localparam int unsigned SEQ_MULT_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_mult_ctrl.sv
// Sequencer for seq_mult: IDLE/CALC/DONE FSM with a WIDTH-step counter.
// Emits load/step/finish strobes for the datapath and a registered busy flag.
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = SEQ_MULT_WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic load,
    output logic step,
    output logic finish,
    output logic busy
);

    // One extra bit keeps the replication below legal for WIDTH=2.
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    // Next-state, counter and strobe decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, counter and busy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-and-add multiplier, fixed WIDTH+2 cycle period.
// Define SEQ_MULT_SIGNED_EN to add the sgn port for two's complement operands.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = SEQ_MULT_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic               sgn,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int unsigned PW = 2 * WIDTH;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             neg);
        return neg ? (-v) : v;
    endfunction

    logic             load_s, step_s, finish_s;
    logic             sgn_s, a_neg_s, b_neg_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s;

    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    p_q, p_d;
    logic             done_q, done_d;

    seq_mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .load   (load_s),
        .step   (step_s),
        .finish (finish_s),
        .busy   (busy)
    );

`ifdef SEQ_MULT_SIGNED_EN
    assign sgn_s = sgn;
`else
    assign sgn_s = 1'b0;
`endif

    // Signed mode works on magnitudes; the sign is reapplied when the result is published.
    assign a_neg_s = sgn_s & a[WIDTH-1];
    assign b_neg_s = sgn_s & b[WIDTH-1];
    assign a_mag_s = magnitude(a, a_neg_s);
    assign b_mag_s = magnitude(b, b_neg_s);

    // Datapath next-state: load operands, one shift-add per step, publish on finish.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        p_d      = p_q;
        done_d   = 1'b0;
        if (load_s) begin
            mcand_d  = {{WIDTH{1'b0}}, a_mag_s};
            mplier_d = b_mag_s;
            acc_d    = '0;
            neg_d    = a_neg_s ^ b_neg_s;
        end else if (step_s) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end else begin
                acc_d = acc_q;
            end
            mcand_d  = {mcand_q[PW-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        end else if (finish_s) begin
            p_d    = neg_q ? (-acc_q) : acc_q;
            done_d = 1'b1;
        end else begin
            done_d = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            p_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            p_q      <= p_d;
            done_q   <= done_d;
        end
    end

    assign p    = p_q;
    assign done = done_q;

endmodule

// File: doc/seq_mult.md
SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; SHALL be legal for 2..32.
REQ-002 Port clk, input, 1, single clock; all state SHALL update on the rising edge.
REQ-003 Port rst, input, 1, reset; synchronous and active-high.
REQ-004 Port start, input, 1, request to begin a multiply.
REQ-005 Port a, input, WIDTH, multiplicand.
REQ-006 Port b, input, WIDTH, multiplier.
REQ-007 Port busy, output, 1, high while a multiply is in progress.
REQ-008 Port done, output, 1, one-cycle pulse marking p valid.
REQ-009 Port p, output, 2*WIDTH, product.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-011 In IDLE with start=1, the block SHALL latch a and b, clear the accumulator and the step counter, and enter CALC on the next edge.
REQ-012 In CALC, each cycle SHALL add the shifted multiplicand to the accumulator if the multiplier LSB is 1, then shift the multiplicand left and the multiplier right.
REQ-013 CALC SHALL last exactly WIDTH cycles, then enter DONE.
REQ-014 In DONE, p SHALL take the final accumulator value and done SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-015 Latency SHALL be fixed: if start is sampled at edge N, done SHALL be high in the cycle following edge N+WIDTH+1.
REQ-016 Latency SHALL NOT depend on operand values; zero operands still take WIDTH CALC cycles.
REQ-017 busy SHALL be 1 in CALC and DONE, and 0 in IDLE.
REQ-018 start SHALL be ignored in CALC and DONE; a, b and the result in progress SHALL NOT be disturbed.
REQ-019 a and b SHALL be sampled only at accept; changes during CALC SHALL have no effect.
REQ-020 p SHALL hold its last result from DONE until the next DONE.
REQ-021 The accumulator SHALL be 2*WIDTH bits with no overflow; the product of two WIDTH-bit unsigned operands SHALL always fit.
REQ-022 start held high continuously SHALL produce back-to-back multiplies, accepted in each IDLE cycle.

Reset
REQ-023 rst=1 SHALL force IDLE, busy=0, done=0, p=0, and a cleared accumulator and counter at the next edge.
REQ-024 rst SHALL take priority over start.
REQ-025 rst asserted in CALC or DONE SHALL abort the operation; no done pulse SHALL follow.

Configuration
REQ-026 With the macro SEQ_MULT_SIGNED_EN defined, a 1-bit input port sgn SHALL exist, sampled with a and b at accept.
REQ-027 With SEQ_MULT_SIGNED_EN defined and sgn=1, a, b and p SHALL be two's complement.
REQ-028 In that signed mode, the block SHALL multiply the operand magnitudes and negate the result when the operand signs differ.
REQ-029 Signed-mode latency SHALL be identical to unsigned latency.
REQ-030 With SEQ_MULT_SIGNED_EN undefined, the sgn port SHALL NOT exist and all operation SHALL be unsigned.

Structure
REQ-031 Package seq_mult_pkg SHALL hold the state enum typedef (IDLE/CALC/DONE) and the default WIDTH constant.
REQ-032 Sub-module seq_mult_ctrl SHALL hold the FSM and step counter, and SHALL drive load/step/finish strobes to the datapath in seq_mult.

Verification
REQ-033 WIDTH=4, a=10, b=4, start pulse -> done after 5 cycles, p=40, busy low afterwards.
REQ-034 WIDTH=4, a=15, b=15 -> p=225; a=0, b=9 -> p=0 with the same 5-cycle latency.
REQ-035 Start a=3, b=5; mid-CALC apply start with a=7, b=7 -> single done, p=15.
REQ-036 Start a=6, b=6; rst in the 2nd CALC cycle -> busy=0, p=0, no done; the following start a=2, b=3 -> p=6.
REQ-037 SEQ_MULT_SIGNED_EN, WIDTH=4, sgn=1: a=-8, b=-8 -> p=64; a=-3, b=5 -> p=8'hF1 (-15).
REQ-038 WIDTH=8, start held high, operand pairs (255,255) then (16,16) -> p=65025, then p=256, with consecutive done pulses 10 cycles apart.
